// File: rtl/ofifo_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : ofifo_collector_if
// Brief    : Lane push / row pop bus between the systolic array south edge,
//            the column re-alignment buffer and the downstream row consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ofifo_collector_if #(
  parameter int COL = 8,
  parameter int BW  = 16
);
  logic [COL-1:0]    wr;
  logic [COL*BW-1:0] in;
  logic              rd;
  logic [COL*BW-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_overflow;

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_overflow
  );

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/ofifo_collector.sv
`default_nettype none
// ============================================================================
// Module   : ofifo_collector
// Brief    : Per-column output FIFOs that re-align skewed partial sums and
//            release one full row per accepted read (1-cycle registered out).
//            Optional macro OFIFO_RELU_EN applies ReLU to captured words.
// Revision : 1.0 - initial release
// ============================================================================
module ofifo_collector #(
  parameter int COL   = 8,
  parameter int BW    = 16,
  parameter int DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  ofifo_collector_if.slave  bus
);
  localparam int           c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [COL-1:0] w_full;
  logic [COL-1:0] w_empty;
  logic           w_pop;
  logic           w_drop;
  logic           r_overflow;

  assign bus.o_valid    = ~|w_empty;
  assign bus.o_full     = |w_full;
  assign w_pop          = bus.rd & bus.o_valid;
  // A pop on a full lane frees its slot on the same edge, so that push is kept.
  assign w_drop         = |(bus.wr & w_full & ~{COL{w_pop}});
  assign bus.o_overflow = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [BW-1:0]   r_mem [DEPTH];
    logic [BW-1:0]   r_out;
    logic [BW-1:0]   w_head;
    logic [BW-1:0]   w_cap;
    logic            w_push;

    assign w_full[i]  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty[i] = (r_wr_ptr == r_rd_ptr);
    assign w_push     = bus.wr[i] & (~w_full[i] | w_pop);
    assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];

`ifdef OFIFO_RELU_EN
    assign w_cap = w_head[BW-1] ? '0 : w_head;
`else
    assign w_cap = w_head;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_out    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
          r_out    <= w_cap;
        end
      end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= bus.in[i*BW +: BW];
      end
    end

    assign bus.out[i*BW +: BW] = r_out;
  end
endmodule
`default_nettype wire

// File: tb/tb_ofifo_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofifo_collector
// Brief    : Randomised self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofifo_collector;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ofifo_collector_if #(.COL(COL), .BW(BW)) bus ();

  ofifo_collector #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane
  logic [BW-1:0]     q [COL][$];
  logic [COL*BW-1:0] m_out = '0;
  logic              m_ovf = 1'b0;
  logic              m_v;
  logic              m_pop;

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] x);
`ifdef OFIFO_RELU_EN
    return x[BW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < COL; i++) q[i].delete();
      m_out = '0;
      m_ovf = 1'b0;
    end else begin
      m_v = 1'b1;
      for (int i = 0; i < COL; i++) if (q[i].size() == 0) m_v = 1'b0;
      m_pop = bus.rd && m_v;
      if (m_pop)
        for (int i = 0; i < COL; i++) m_out[i*BW +: BW] = relu(q[i].pop_front());
      for (int i = 0; i < COL; i++) begin
        if (bus.wr[i]) begin
          if (q[i].size() < DEPTH) q[i].push_back(bus.in[i*BW +: BW]);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [COL*BW-1:0] act,
                       input logic [COL*BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ev, ef;
    ev = 1'b1;
    ef = 1'b0;
    for (int i = 0; i < COL; i++) begin
      if (q[i].size() == 0) ev = 1'b0;
      if (q[i].size() == DEPTH) ef = 1'b1;
    end
    check("model_valid", {127'd0, bus.o_valid}, {127'd0, ev});
    check("model_full", {127'd0, bus.o_full}, {127'd0, ef});
    check("model_ovf", {127'd0, bus.o_overflow}, {127'd0, m_ovf});
    check("model_out", bus.out, m_out);
  end

  function automatic logic [COL*BW-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [COL*BW-1:0] d;
    logic [COL*BW-1:0] exp_row;
    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle reads after reset are ignored
    repeat (3) cyc('0, '0, 1'b1);
    check("idle_out", bus.out, '0);
    check("idle_valid", {127'd0, bus.o_valid}, 128'd0);
    check("idle_ovf", {127'd0, bus.o_overflow}, 128'd0);

    // Skewed fill, one lane per cycle
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(100 + i);
      cyc(COL'(1) << i, d, 1'b0);
      if (i == COL - 2) check("skew_not_valid", {127'd0, bus.o_valid}, 128'd0);
    end
    check("skew_valid", {127'd0, bus.o_valid}, 128'd1);
    cyc('0, '0, 1'b1);
    exp_row = '0;
    for (int i = 0; i < COL; i++) exp_row[i*BW +: BW] = BW'(100 + i);
    check("skew_row", bus.out, exp_row);
    check("skew_drained", {127'd0, bus.o_valid}, 128'd0);

    // Lane 3 full then overflow
    for (int k = 0; k < DEPTH; k++) cyc(8'h08, rnd_row(), 1'b0);
    check("lane3_full", {127'd0, bus.o_full}, 128'd1);
    check("lane3_no_ovf", {127'd0, bus.o_overflow}, 128'd0);
    cyc(8'h08, rnd_row(), 1'b0);
    check("lane3_ovf", {127'd0, bus.o_overflow}, 128'd1);
    repeat (3) cyc('0, '0, 1'b1);
    check("lane3_ovf_sticky", {127'd0, bus.o_overflow}, 128'd1);
    pulse_reset();
    check("ovf_cleared", {127'd0, bus.o_overflow}, 128'd0);

    // All full, streaming push+pop across pointer wrap
    for (int k = 0; k < DEPTH; k++) cyc('1, rnd_row(), 1'b0);
    check("all_full", {127'd0, bus.o_full}, 128'd1);
    for (int k = 0; k < 40; k++) cyc('1, rnd_row(), 1'b1);
    check("stream_full", {127'd0, bus.o_full}, 128'd1);
    check("stream_no_ovf", {127'd0, bus.o_overflow}, 128'd0);
    for (int k = 0; k < DEPTH; k++) cyc('0, '0, 1'b1);
    check("stream_empty", {127'd0, bus.o_valid}, 128'd0);

    // Random traffic
    for (int k = 0; k < 600; k++)
      cyc(COL'($urandom), rnd_row(), 1'($urandom_range(0, 2) != 0));
    pulse_reset();

    // Signed values through the output stage
    d = rnd_row();
    d[0 +: BW]  = 16'hFFFB;
    d[BW +: BW] = 16'h0007;
    cyc('1, d, 1'b0);
    cyc('0, '0, 1'b1);
`ifdef OFIFO_RELU_EN
    check("neg_lane", {112'd0, bus.out[0 +: BW]}, 128'd0);
`else
    check("neg_lane", {112'd0, bus.out[0 +: BW]}, 128'h0FFFB);
`endif
    check("pos_lane", {112'd0, bus.out[BW +: BW]}, 128'h00007);

    // Async reset with rows buffered
    for (int k = 0; k < 5; k++) cyc('1, rnd_row(), 1'b0);
    cyc('0, '0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out", bus.out, '0);
    check("async_valid", {127'd0, bus.o_valid}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) cyc('0, '0, 1'b1);
    check("post_rst_out", bus.out, '0);
    cyc(8'h7F, rnd_row(), 1'b1);
    cyc('0, '0, 1'b1);
    check("partial_not_valid", {127'd0, bus.o_valid}, 128'd0);
    cyc(8'h80, rnd_row(), 1'b0);
    check("refill_valid", {127'd0, bus.o_valid}, 128'd1);
    cyc('0, '0, 1'b1);
    repeat (2) cyc('0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
